// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I memory-access encodings and LSU state type
package core_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LW  = 3'b010,
        MEM_LBU = 3'b011,
        MEM_LHU = 3'b100,
        MEM_SB  = 3'b101,
        MEM_SH  = 3'b110,
        MEM_SW  = 3'b111
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } mem_err_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [1:0] mem_size(input logic [2:0] ctrl);
        case (ctrl)
            MEM_LB, MEM_LBU, MEM_SB: mem_size = SIZE_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: mem_size = SIZE_HALF;
            default:                 mem_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - single-outstanding data-memory request/acknowledge bus
interface load_store_unit_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWdata;
    logic        busAck;
    logic [31:0] busRdata;

    modport master (
        output busReq, busWe, busAddr, busBe, busWdata,
        input  busAck, busRdata
    );

    modport slave (
        input  busReq, busWe, busAddr, busBe, busWdata,
        output busAck, busRdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and access legality checks
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  mem_ctrl,
    input  logic        mem_rd,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic        illegal
);
    logic [1:0]  size;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        size       = mem_size(mem_ctrl);
        illegal    = mem_rd ? (mem_ctrl >= MEM_SB) : (mem_ctrl < MEM_SB);
        misaligned = ((size == SIZE_HALF) && addr_lo[0]) ||
                     ((size == SIZE_WORD) && (addr_lo != 2'b00));

        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                bus_wdata = wdata;
            end
        endcase

        shifted = bus_rdata >> {addr_lo, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        // Stores and illegal codes return zero so rdata is never stale bus data
        case (mem_ctrl)
            MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data = {24'h0, ld_byte};
            MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data = {16'h0, ld_half};
            MEM_LW:  ld_data = bus_rdata;
            default: ld_data = 32'h0;
        endcase
        if (!mem_rd) ld_data = 32'h0;
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store FSM with bus timeout and fault reporting
module load_store_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reqValid,
    input  logic [2:0]         memCtrl,
    input  logic               memRD,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               stall,
    output logic               done,
    output logic [31:0]        rdata,
    output logic [1:0]         memErr,
    load_store_unit_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT);

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic [2:0]  ctrl_q;
    logic        rd_q;
    logic [1:0]  alo_q;

    logic [2:0]  a_ctrl;
    logic        a_rd;
    logic [1:0]  a_lo;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic        misaligned;
    logic        illegal;

    // Live pipeline inputs are only meaningful at accept; afterwards the latched copy drives the aligner
    assign a_ctrl = (state == LSU_IDLE) ? memCtrl   : ctrl_q;
    assign a_rd   = (state == LSU_IDLE) ? memRD     : rd_q;
    assign a_lo   = (state == LSU_IDLE) ? addr[1:0] : alo_q;

    lsu_align u_align (
        .mem_ctrl   (a_ctrl),
        .mem_rd     (a_rd),
        .addr_lo    (a_lo),
        .wdata      (wdata),
        .bus_rdata  (bus.busRdata),
        .be         (be),
        .bus_wdata  (wd),
        .ld_data    (ld),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign stall = reqValid && (state != LSU_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LSU_IDLE;
            cnt          <= '0;
            ctrl_q       <= 3'b000;
            rd_q         <= 1'b0;
            alo_q        <= 2'b00;
            done         <= 1'b0;
            rdata        <= 32'h0;
            memErr       <= ERR_OK;
            bus.busReq   <= 1'b0;
            bus.busWe    <= 1'b0;
            bus.busAddr  <= 32'h0;
            bus.busBe    <= 4'h0;
            bus.busWdata <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (reqValid) begin
                        ctrl_q <= memCtrl;
                        rd_q   <= memRD;
                        alo_q  <= addr[1:0];
                        if (illegal) begin
                            state  <= LSU_RESP;
                            done   <= 1'b1;
                            rdata  <= 32'h0;
                            memErr <= ERR_ILLEGAL;
                        end else if (misaligned) begin
                            state  <= LSU_RESP;
                            done   <= 1'b1;
                            rdata  <= 32'h0;
                            memErr <= ERR_MISALIGN;
                        end else begin
                            state        <= LSU_REQ;
                            cnt          <= '0;
                            bus.busReq   <= 1'b1;
                            bus.busWe    <= !memRD;
                            bus.busAddr  <= {addr[31:2], 2'b00};
                            bus.busBe    <= be;
                            bus.busWdata <= wd;
                        end
                    end
                end
                LSU_REQ: begin
                    // Ack is checked first so it wins over a coincident timeout
                    if (bus.busAck) begin
                        state      <= LSU_RESP;
                        done       <= 1'b1;
                        rdata      <= ld;
                        memErr     <= ERR_OK;
                        bus.busReq <= 1'b0;
                        bus.busWe  <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state      <= LSU_RESP;
                        done       <= 1'b1;
                        rdata      <= 32'h0;
                        memErr     <= ERR_TIMEOUT;
                        bus.busReq <= 1'b0;
                        bus.busWe  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LSU_RESP: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic [2:0]  memCtrl = 3'b000;
    logic        memRD = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  memErr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_err_q[$];
    int          exp_cyc_q[$];

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reqValid (reqValid),
        .memCtrl  (memCtrl),
        .memRD    (memRD),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .done     (done),
        .rdata    (rdata),
        .memErr   (memErr),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                if (exp_rdata_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("resp_rdata", rdata, exp_rdata_q.pop_front());
                    chk("resp_memErr", {30'h0, memErr}, {30'h0, exp_err_q.pop_front()});
                    chk("resp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
        end
    end

    task automatic access(input string name, input logic [2:0] ctrl, input logic rd,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int wait_n, input bit ack_en,
                          input logic [31:0] exp_rd, input logic [1:0] exp_err,
                          input bit exp_bus, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int  lat;
        int  stall_n;
        int  req_n;
        bit  seen;
        lat     = exp_bus ? wait_n + 2 : 1;
        stall_n = 0;
        req_n   = 0;
        seen    = 1'b0;
        @(negedge clk);
        reqValid = 1'b1;
        memCtrl  = ctrl;
        memRD    = rd;
        addr     = a;
        wdata    = wd;
        bus.busRdata = rword;
        exp_rdata_q.push_back(exp_rd);
        exp_err_q.push_back(exp_err);
        exp_cyc_q.push_back(cyc + lat);
        for (int k = 0; k < 100 && !seen; k++) begin
            #1;
            if (stall) stall_n++;
            bus.busAck = 1'b0;
            if (bus.busReq) begin
                chk({name, "_busAddr"},  bus.busAddr,  {a[31:2], 2'b00});
                chk({name, "_busBe"},    {28'h0, bus.busBe}, {28'h0, exp_be});
                chk({name, "_busWdata"}, bus.busWdata, exp_wd);
                chk({name, "_busWe"},    {31'h0, bus.busWe}, {31'h0, !rd});
                bus.busAck = ack_en && (req_n == wait_n);
                req_n++;
            end
            if (done) begin
                seen = 1'b1;
                reqValid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.busAck = 1'b0;
        reqValid = 1'b0;
        if (!seen) chk({name, "_done_seen"}, 32'd0, 32'd1);
        chk({name, "_stall_cycles"}, 32'(stall_n), 32'(lat));
        chk({name, "_busReq_cycles"}, 32'(req_n), exp_bus ? 32'(wait_n + 1) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.busAck   = 1'b0;
        bus.busRdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busReq",   {31'h0, bus.busReq}, 32'h0);
        chk("rst_busWe",    {31'h0, bus.busWe},  32'h0);
        chk("rst_busAddr",  bus.busAddr,  32'h0);
        chk("rst_busBe",    {28'h0, bus.busBe},  32'h0);
        chk("rst_busWdata", bus.busWdata, 32'h0);
        chk("rst_done",     {31'h0, done}, 32'h0);
        chk("rst_rdata",    rdata, 32'h0);
        chk("rst_memErr",   {30'h0, memErr}, 32'h0);
        chk("rst_stall",    {31'h0, stall}, 32'h0);
        rst_n = 1'b1;

        //      name        ctrl    rd  addr          wdata         busRdata      wait ack  exp_rdata     err    bus  be       busWdata
        access("lb_sext",   3'b000, 1, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 1, 32'hFFFF_FF80, 2'b00, 1, 4'b1000, 32'h0);
        access("sh_wait3",  3'b110, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 1, 32'h0,         2'b00, 1, 4'b1100, 32'hABCD_ABCD);
        access("lw_mis",    3'b010, 1, 32'h0000_0006, 32'h0,        32'h0,         0, 0, 32'h0,         2'b01, 0, 4'b0000, 32'h0);
        access("lhu_mis",   3'b100, 1, 32'h0000_0007, 32'h0,        32'h0,         0, 0, 32'h0,         2'b01, 0, 4'b0000, 32'h0);
        access("ld_ill",    3'b110, 1, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 32'h0,         2'b10, 0, 4'b0000, 32'h0);
        access("st_ill",    3'b010, 0, 32'h0000_0008, 32'h0,        32'h0,         0, 0, 32'h0,         2'b10, 0, 4'b0000, 32'h0);
        access("lw_tmo",    3'b010, 1, 32'h0000_0040, 32'h0,        32'h0,         3, 0, 32'h0,         2'b11, 1, 4'b1111, 32'h0);
        access("lw_ack4",   3'b010, 1, 32'h0000_0044, 32'h0,        32'hDEAD_BEEF, 3, 1, 32'hDEAD_BEEF, 2'b00, 1, 4'b1111, 32'h0);
        access("lh_sext",   3'b001, 1, 32'h0000_0002, 32'h0,        32'h8001_1234, 1, 1, 32'hFFFF_8001, 2'b00, 1, 4'b1100, 32'h0);
        access("sb_lane1",  3'b101, 0, 32'h0000_0001, 32'h0000_0055, 32'h0,        0, 1, 32'h0,         2'b00, 1, 4'b0010, 32'h5555_5555);
        access("sw_full",   3'b111, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h0,         2'b00, 1, 4'b1111, 32'hCAFE_F00D);

        // Reset in the middle of a bus request must drop busReq without a clock edge
        @(negedge clk);
        reqValid = 1'b1;
        memCtrl  = 3'b010;
        memRD    = 1'b1;
        addr     = 32'h0000_0050;
        @(negedge clk);
        #1;
        chk("mid_req_busReq", {31'h0, bus.busReq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busReq", {31'h0, bus.busReq}, 32'h0);
        reqValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        access("lbu_post",  3'b011, 1, 32'h0000_3001, 32'h0,        32'h0000_9A00, 0, 1, 32'h0000_009A, 2'b00, 1, 4'b0010, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_rdata_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
